// File: rtl/alu_op_driver_if.sv
// Bundle of request, ALU-drive, response and statistics signals for alu_op_driver.
// The master modport is the driver's view; the slave modport is the view of the
// environment that issues requests, models the ALU and consumes responses.
interface alu_op_driver_if #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 8
);
    // request channel
    logic             i_req_valid;
    logic             o_req_ready;
    logic [WIDTH-1:0] i_req_arg0;
    logic [WIDTH-1:0] i_req_arg1;
    logic [1:0]       i_req_oper;

    // ALU operand / result side
    logic [WIDTH-1:0] o_arg0;
    logic [WIDTH-1:0] o_arg1;
    logic [1:0]       o_oper;
    logic [WIDTH-1:0] i_alu_result;
    logic [3:0]       i_alu_flag;

    // response channel
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [WIDTH-1:0] o_rsp_result;
    logic [3:0]       o_rsp_flag;
    logic [1:0]       o_rsp_oper;

    // statistics
    logic             i_clr_cnt;
    logic [CNTW-1:0]  o_err_cnt;
    logic [CNTW-1:0]  o_ovf_cnt;

    modport master (
        input  i_req_valid, i_req_arg0, i_req_arg1, i_req_oper,
        output o_req_ready,
        output o_arg0, o_arg1, o_oper,
        input  i_alu_result, i_alu_flag,
        output o_rsp_valid, o_rsp_result, o_rsp_flag, o_rsp_oper,
        input  i_rsp_ready,
        input  i_clr_cnt,
        output o_err_cnt, o_ovf_cnt
    );

    modport slave (
        output i_req_valid, i_req_arg0, i_req_arg1, i_req_oper,
        input  o_req_ready,
        input  o_arg0, o_arg1, o_oper,
        output i_alu_result, i_alu_flag,
        input  o_rsp_valid, o_rsp_result, o_rsp_flag, o_rsp_oper,
        output i_rsp_ready,
        output i_clr_cnt,
        input  o_err_cnt, o_ovf_cnt
    );
endinterface

// File: rtl/alu_op_driver.sv
// Request-side master for the 4-operation ALU. One operation in flight at a time:
// accept a request, drive the ALU operands, wait LAT cycles, capture result and
// flags, and hold them on the response channel until consumed. Keeps saturating
// error and overflow counters of captured responses.
module alu_op_driver #(
    parameter int WIDTH = 4,
    parameter int LAT   = 1,   // ALU register stages, 0..15
    parameter int CNTW  = 8
) (
    input logic             i_clk,
    input logic             i_rstn,
    alu_op_driver_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic       accept;
    logic       capture;
    logic       req_ready_next;
    logic       rsp_valid_next;

    // Increment by one unless disabled or already at the all-ones ceiling.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] value,
                                                input logic            en);
        if (en && (value != {CNTW{1'b1}}))
            return value + {{(CNTW-1){1'b0}}, 1'b1};
        return value;
    endfunction

    // Request handshake uses the registered ready, so nothing is accepted on the
    // first edge after reset release.
    assign accept  = (state == IDLE) && bus.i_req_valid && bus.o_req_ready;
    // The ALU output is sampled once the wait counter has drained.
    assign capture = (state == WAIT) && (wait_cnt == 4'd0);

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)          state_next = WAIT;
            WAIT:    if (capture)         state_next = RESP;
            RESP:    if (bus.i_rsp_ready) state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // Output decode: handshake outputs are registered versions of the next state.
    always_comb begin
        req_ready_next = (state_next == IDLE);
        rsp_valid_next = (state_next == RESP);
    end

    // Registered handshake outputs; no input reaches them combinationally.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            bus.o_req_ready <= 1'b0;
            bus.o_rsp_valid <= 1'b0;
        end else begin
            bus.o_req_ready <= req_ready_next;
            bus.o_rsp_valid <= rsp_valid_next;
        end
    end

    // Wait counter: loaded with the ALU latency on accept, drained in WAIT.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= 4'(LAT);
        end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Operand registers: loaded on accept, held until the next accepted request.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            bus.o_arg0 <= '0;
            bus.o_arg1 <= '0;
            bus.o_oper <= 2'b00;
        end else if (accept) begin
            bus.o_arg0 <= bus.i_req_arg0;
            bus.o_arg1 <= bus.i_req_arg1;
            bus.o_oper <= bus.i_req_oper;
        end
    end

    // Response capture: flags are taken verbatim from the ALU and held afterwards.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            bus.o_rsp_result <= '0;
            bus.o_rsp_flag   <= 4'b0000;
            bus.o_rsp_oper   <= 2'b00;
        end else if (capture) begin
            bus.o_rsp_result <= bus.i_alu_result;
            bus.o_rsp_flag   <= bus.i_alu_flag;
            bus.o_rsp_oper   <= bus.o_oper;
        end
    end

    // Statistic counters: a clear overrides any increment on the same edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            bus.o_err_cnt <= '0;
            bus.o_ovf_cnt <= '0;
        end else if (bus.i_clr_cnt) begin
            bus.o_err_cnt <= '0;
            bus.o_ovf_cnt <= '0;
        end else if (capture) begin
            bus.o_err_cnt <= sat_inc(bus.o_err_cnt, bus.i_alu_flag[0]);
            bus.o_ovf_cnt <= sat_inc(bus.o_ovf_cnt, bus.i_alu_flag[3]);
        end
    end

endmodule

// File: tb/tb_alu_op_driver.sv
// Directed bench for alu_op_driver: a LAT=1/CNTW=2 instance with a one-stage ALU
// model, plus LAT=0 and LAT=4 instances fed a cycle-marker result to pin the
// capture edge.
module tb_alu_op_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_op_driver_if #(.WIDTH(4), .CNTW(2)) bus_m ();
    alu_op_driver_if #(.WIDTH(4), .CNTW(8)) bus_0 ();
    alu_op_driver_if #(.WIDTH(4), .CNTW(8)) bus_4 ();

    alu_op_driver #(.WIDTH(4), .LAT(1), .CNTW(2)) u_main (.i_clk(clk), .i_rstn(rst_n), .bus(bus_m));
    alu_op_driver #(.WIDTH(4), .LAT(0), .CNTW(8)) u_lat0 (.i_clk(clk), .i_rstn(rst_n), .bus(bus_0));
    alu_op_driver #(.WIDTH(4), .LAT(4), .CNTW(8)) u_lat4 (.i_clk(clk), .i_rstn(rst_n), .bus(bus_4));

    int n_vec = 0;
    int n_err = 0;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ALU reference: returns {result, flag} with flag = {ovf, pos, neg, err}.
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] op);
        logic [3:0] r;
        logic       err, ovf, run;
        r = 4'd0; err = 1'b0; ovf = 1'b0; run = 1'b1;
        case (op)
            2'b00: begin
                r   = a - b;
                ovf = (a[3] != b[3]) && (r[3] != a[3]);
            end
            2'b01: r = ~(a & b);
            2'b10: begin
                for (int i = 0; i < 4; i++) begin
                    if (run && a[i]) r = r + 4'd1;
                    else run = 1'b0;
                end
            end
            default: begin
                case (a)
                    4'b0001: r = 4'd0;
                    4'b0010: r = 4'd1;
                    4'b0100: r = 4'd2;
                    4'b1000: r = 4'd3;
                    default: err = 1'b1;
                endcase
            end
        endcase
        return {r, ovf, (!err && !r[3] && (r != 4'd0)), (!err && r[3]), err};
    endfunction

    // One-stage ALU model for the main instance, with injectable flag bits.
    logic [3:0] m_res = 4'd0;
    logic [3:0] m_flag = 4'd0;
    logic [3:0] alu_flag_or = 4'd0;
    always @(posedge clk) {m_res, m_flag} <= alu_model(bus_m.o_arg0, bus_m.o_arg1, bus_m.o_oper);
    assign bus_m.i_alu_result = m_res;
    assign bus_m.i_alu_flag   = m_flag | alu_flag_or;

    // Cycle markers for the latency instances: 8 after the accept edge, +1 per edge.
    logic [3:0] k0 = 4'd0;
    logic [3:0] k4 = 4'd0;
    always @(posedge clk) begin
        k0 <= (bus_0.i_req_valid && bus_0.o_req_ready) ? 4'd8 : k0 + 4'd1;
        k4 <= (bus_4.i_req_valid && bus_4.o_req_ready) ? 4'd8 : k4 + 4'd1;
    end
    assign bus_0.i_alu_result = k0;
    assign bus_4.i_alu_result = k4;
    assign bus_0.i_alu_flag   = 4'd0;
    assign bus_4.i_alu_flag   = 4'd0;

    // Handshake log for the back-to-back run.
    int         cyc = 0;
    logic       log_en = 1'b0;
    int         acc_cyc[$];
    logic [3:0] rsp_res[$];
    logic [3:0] rsp_flg[$];
    logic [1:0] rsp_op[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (log_en && bus_m.i_req_valid && bus_m.o_req_ready) acc_cyc.push_back(cyc);
        if (log_en && bus_m.o_rsp_valid && bus_m.i_rsp_ready) begin
            rsp_res.push_back(bus_m.o_rsp_result);
            rsp_flg.push_back(bus_m.o_rsp_flag);
            rsp_op.push_back(bus_m.o_rsp_oper);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; returns 1 ns after the accept edge.
    task automatic send_req(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        bit ok;
        ok = 1'b0;
        bus_m.i_req_arg0  = a;
        bus_m.i_req_arg1  = b;
        bus_m.i_req_oper  = op;
        bus_m.i_req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus_m.o_req_ready) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        bus_m.i_req_valid = 1'b0;
        if (!ok) chk("req_accept_timeout", 32'd0, 32'd1);
    endtask

    // Wait until a response is valid; returns 1 ns after the capture edge.
    task automatic wait_rsp();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus_m.o_rsp_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_res [4];
        logic [1:0] exp_op  [4];
        logic [3:0] sat_exp;

        bus_m.i_req_valid = 1'b0; bus_m.i_req_arg0 = 4'd0; bus_m.i_req_arg1 = 4'd0;
        bus_m.i_req_oper = 2'b00; bus_m.i_rsp_ready = 1'b0; bus_m.i_clr_cnt = 1'b0;
        bus_0.i_req_valid = 1'b0; bus_0.i_req_arg0 = 4'd0; bus_0.i_req_arg1 = 4'd0;
        bus_0.i_req_oper = 2'b00; bus_0.i_rsp_ready = 1'b0; bus_0.i_clr_cnt = 1'b0;
        bus_4.i_req_valid = 1'b0; bus_4.i_req_arg0 = 4'd0; bus_4.i_req_arg1 = 4'd0;
        bus_4.i_req_oper = 2'b00; bus_4.i_rsp_ready = 1'b0; bus_4.i_clr_cnt = 1'b0;

        // Reset values
        #22;
        chk("rst_req_ready", 32'(bus_m.o_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus_m.o_rsp_valid), 32'd0);
        chk("rst_arg0",      32'(bus_m.o_arg0),      32'd0);
        chk("rst_err_cnt",   32'(bus_m.o_err_cnt),   32'd0);

        // Basic sub 3-5 presented before release: not accepted on the first edge
        bus_m.i_req_arg0 = 4'd3; bus_m.i_req_arg1 = 4'd5; bus_m.i_req_oper = 2'b00;
        bus_m.i_req_valid = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        chk("rel_req_ready", 32'(bus_m.o_req_ready), 32'd1);
        chk("rel_no_accept", 32'(bus_m.o_arg0),      32'd0);
        step();
        bus_m.i_req_valid = 1'b0;
        chk("basic_arg0",  32'(bus_m.o_arg0),      32'd3);
        chk("basic_arg1",  32'(bus_m.o_arg1),      32'd5);
        chk("basic_oper",  32'(bus_m.o_oper),      32'd0);
        chk("basic_busy",  32'(bus_m.o_req_ready), 32'd0);
        step();
        chk("basic_e1_valid", 32'(bus_m.o_rsp_valid), 32'd0);
        step();
        chk("basic_e2_valid", 32'(bus_m.o_rsp_valid),  32'd1);
        chk("basic_result",   32'(bus_m.o_rsp_result), 32'hE);
        chk("basic_flag",     32'(bus_m.o_rsp_flag),   32'b0010);
        chk("basic_rsp_oper", 32'(bus_m.o_rsp_oper),   32'd0);
        chk("basic_err_cnt",  32'(bus_m.o_err_cnt),    32'd0);
        chk("basic_ovf_cnt",  32'(bus_m.o_ovf_cnt),    32'd0);

        // Response backpressure with a competing request
        bus_m.i_req_arg0 = 4'd4; bus_m.i_req_arg1 = 4'd2; bus_m.i_req_oper = 2'b01;
        bus_m.i_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid",     32'(bus_m.o_rsp_valid),  32'd1);
            chk("bp_result",    32'(bus_m.o_rsp_result), 32'hE);
            chk("bp_req_ready", 32'(bus_m.o_req_ready),  32'd0);
            chk("bp_arg0_hold", 32'(bus_m.o_arg0),       32'd3);
        end
        bus_m.i_rsp_ready = 1'b1;
        step();
        chk("hs_valid_low",   32'(bus_m.o_rsp_valid),  32'd0);
        chk("hs_req_ready",   32'(bus_m.o_req_ready),  32'd1);
        chk("hs_result_hold", 32'(bus_m.o_rsp_result), 32'hE);
        step();
        bus_m.i_req_valid = 1'b0;
        chk("reacc_arg0", 32'(bus_m.o_arg0), 32'd4);
        chk("reacc_oper", 32'(bus_m.o_oper), 32'd1);
        wait_rsp();
        chk("nand_result", 32'(bus_m.o_rsp_result), 32'hF);
        chk("nand_flag",   32'(bus_m.o_rsp_flag),   32'b0010);
        chk("nand_oper",   32'(bus_m.o_rsp_oper),   32'd1);

        // Counter saturation at 3 with CNTW=2
        alu_flag_or = 4'b1001;
        for (int n = 1; n <= 5; n++) begin
            send_req(4'd0, 4'd0, 2'b00);
            wait_rsp();
            sat_exp = (n < 3) ? 4'(n) : 4'd3;
            chk("sat_flag",    32'(bus_m.o_rsp_flag), 32'b1001);
            chk("sat_err_cnt", 32'(bus_m.o_err_cnt),  32'(sat_exp));
            chk("sat_ovf_cnt", 32'(bus_m.o_ovf_cnt),  32'(sat_exp));
        end

        // Clear coincident with a capture: clear wins
        send_req(4'd0, 4'd0, 2'b00);
        step();
        bus_m.i_clr_cnt = 1'b1;
        step();
        bus_m.i_clr_cnt = 1'b0;
        chk("clrcap_valid", 32'(bus_m.o_rsp_valid), 32'd1);
        chk("clrcap_err",   32'(bus_m.o_err_cnt),   32'd0);
        chk("clrcap_ovf",   32'(bus_m.o_ovf_cnt),   32'd0);
        send_req(4'd0, 4'd0, 2'b00);
        wait_rsp();
        chk("post_clr_err", 32'(bus_m.o_err_cnt), 32'd1);
        chk("post_clr_ovf", 32'(bus_m.o_ovf_cnt), 32'd1);
        step();
        bus_m.i_clr_cnt = 1'b1;
        step();
        bus_m.i_clr_cnt = 1'b0;
        chk("idle_clr_err", 32'(bus_m.o_err_cnt), 32'd0);
        chk("idle_clr_ovf", 32'(bus_m.o_ovf_cnt), 32'd0);
        alu_flag_or = 4'b0000;

        // Back-to-back: sub 7-2, nand C,A, starting-ones 0111, decode 0100
        exp_res[0] = 4'd5; exp_op[0] = 2'b00;
        exp_res[1] = 4'd7; exp_op[1] = 2'b01;
        exp_res[2] = 4'd3; exp_op[2] = 2'b10;
        exp_res[3] = 4'd2; exp_op[3] = 2'b11;
        log_en = 1'b1;
        send_req(4'd7,    4'd2,   2'b00);
        send_req(4'hC,    4'hA,   2'b01);
        send_req(4'b0111, 4'd0,   2'b10);
        send_req(4'b0100, 4'd0,   2'b11);
        for (int i = 0; i < 50 && rsp_res.size() < 4; i++) step();
        log_en = 1'b0;
        chk("b2b_rsp_count", 32'(rsp_res.size()), 32'd4);
        chk("b2b_acc_count", 32'(acc_cyc.size()), 32'd4);
        if (rsp_res.size() == 4 && acc_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("b2b_result", 32'(rsp_res[i]), 32'(exp_res[i]));
                chk("b2b_flag",   32'(rsp_flg[i]), 32'b0100);
                chk("b2b_oper",   32'(rsp_op[i]),  32'(exp_op[i]));
            end
            for (int i = 0; i < 3; i++)
                chk("b2b_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd4);
        end

        // LAT sweep: LAT=0 captures at E0+1, LAT=4 at E0+5
        bus_0.i_req_oper = 2'b11; bus_0.i_req_valid = 1'b1;
        bus_4.i_req_oper = 2'b11; bus_4.i_req_valid = 1'b1;
        chk("lat0_ready", 32'(bus_0.o_req_ready), 32'd1);
        chk("lat4_ready", 32'(bus_4.o_req_ready), 32'd1);
        step();
        bus_0.i_req_valid = 1'b0;
        bus_4.i_req_valid = 1'b0;
        chk("lat0_e0_valid", 32'(bus_0.o_rsp_valid), 32'd0);
        chk("lat4_e0_valid", 32'(bus_4.o_rsp_valid), 32'd0);
        for (int j = 1; j <= 6; j++) begin
            step();
            chk("lat0_valid", 32'(bus_0.o_rsp_valid), 32'd1);
            chk("lat4_valid", 32'(bus_4.o_rsp_valid), 32'(j >= 5));
        end
        chk("lat0_result", 32'(bus_0.o_rsp_result), 32'h8);
        chk("lat4_result", 32'(bus_4.o_rsp_result), 32'hC);
        chk("lat4_oper",   32'(bus_4.o_rsp_oper),   32'd3);
        bus_0.i_rsp_ready = 1'b1;
        bus_4.i_rsp_ready = 1'b1;
        step();
        chk("lat0_hs", 32'(bus_0.o_rsp_valid), 32'd0);
        chk("lat4_hs", 32'(bus_4.o_rsp_valid), 32'd0);

        // Mid-operation reset during WAIT
        send_req(4'd1, 4'd2, 2'b00);
        step();
        rst_n = 1'b0;
        #2;
        chk("mrst_req_ready", 32'(bus_m.o_req_ready),  32'd0);
        chk("mrst_rsp_valid", 32'(bus_m.o_rsp_valid),  32'd0);
        chk("mrst_arg0",      32'(bus_m.o_arg0),       32'd0);
        chk("mrst_arg1",      32'(bus_m.o_arg1),       32'd0);
        chk("mrst_result",    32'(bus_m.o_rsp_result), 32'd0);
        chk("mrst_rsp_oper",  32'(bus_m.o_rsp_oper),   32'd0);
        chk("mrst_flag",      32'(bus_m.o_rsp_flag),   32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("mrst_rel_ready", 32'(bus_m.o_req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("mrst_no_rsp", 32'(bus_m.o_rsp_valid), 32'd0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_op_driver.md
# alu_op_driver

Request-side master for the 4-operation ALU. Accepts operation requests over a valid/ready handshake, drives the ALU operand and opcode inputs, and waits a fixed, parameterised ALU latency. It then captures the ALU result and flags and returns them over a valid/ready response handshake. It also keeps saturating error and overflow counters for the status block.

## Interface
- WIDTH, 4, operand/result width; must equal the ALU WIDTH.
- LAT, 1, number of ALU register stages between operands and result; legal 0..15 (0 = combinational ALU).
- CNTW, 8, width of the statistic counters.

- i_clk  in  1  clock; all logic on the rising edge.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request ready.
- i_req_arg0  in  WIDTH  first operand.
- i_req_arg1  in  WIDTH  second operand.
- i_req_oper  in  2  opcode: 00 sub, 01 nand, 10 starting-ones, 11 one-hot→U2 decode.
- o_arg0  out  WIDTH  to ALU i_arg0.
- o_arg1  out  WIDTH  to ALU i_arg1.
- o_oper  out  2  to ALU i_oper.
- i_alu_result  in  WIDTH  from ALU o_result.
- i_alu_flag  in  4  from ALU o_flag: [0] err, [1] neg, [2] pos, [3] overflow.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response ready.
- o_rsp_result  out  WIDTH  captured result.
- o_rsp_flag  out  4  captured flags, same bit map as i_alu_flag.
- o_rsp_oper  out  2  opcode of the op that produced the response.
- i_clr_cnt  in  1  synchronous clear of both counters.
- o_err_cnt  out  CNTW  responses captured with flag[0]=1, saturating.
- o_ovf_cnt  out  CNTW  responses captured with flag[3]=1, saturating.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - o_req_ready=1.
  - A handshake (i_req_valid & o_req_ready at an edge) registers arg0/arg1/oper into o_arg0/o_arg1/o_oper.
  - It also loads the wait counter with LAT and moves to WAIT.
- **WAIT:**
  - o_req_ready=0.
  - If the counter is nonzero, decrement it.
  - If the counter is zero, capture i_alu_result→o_rsp_result, i_alu_flag→o_rsp_flag and o_oper→o_rsp_oper, set o_rsp_valid, update counters, and go to RESP.
- **RESP:**
  - o_rsp_valid=1 and o_rsp_* stay stable until i_rsp_ready=1 at an edge.
  - On that edge, clear o_rsp_valid and go to IDLE.
- **Operand hold:** o_arg0/o_arg1/o_oper hold their value from acceptance until the next accepted request, including through RESP and IDLE.
- **Response hold:** o_rsp_result/flag/oper hold their last captured value after the handshake.
- **Throughput:** no overlap; one request is in flight at a time.
- **Counter update:**
  - On capture, o_err_cnt increments if flag[0]=1 and o_ovf_cnt increments if flag[3]=1.
  - Each counter saturates at 2^CNTW−1 with no wrap.
  - If i_clr_cnt is high on the capture edge, the clear wins: counters go to 0 and that capture's increment is dropped.
  - i_clr_cnt in any other cycle zeroes both counters.
- **Flags:** flags are captured verbatim. The block does not recompute neg/pos from the result.
- **Input ignore rules:** i_req_* is ignored outside IDLE. i_rsp_ready is ignored outside RESP.

## Timing
- **Reset values:**
  - o_req_ready=0, o_rsp_valid=0, o_arg0=0, o_arg1=0, o_oper=0, o_rsp_result=0, o_rsp_flag=0, o_rsp_oper=0, o_err_cnt=0, o_ovf_cnt=0.
  - State=IDLE, wait counter=0.
- **Reset release:** o_req_ready is a flop. It rises on the first edge with i_rstn=1, so no request can be accepted on that edge.
- **Latency:**
  - Request accepted at edge E0; o_arg* valid after E0.
  - Capture happens at edge E0+LAT+1; o_rsp_valid is high from after E0+LAT+1.
  - LAT=0 gives capture at E0+1. LAT=1 gives capture at E0+2.
- **Re-acceptance:** with response handshake at edge R, o_req_ready=1 after R, and the next accept is possible at R+1.
- **Minimum period:** request-to-request is LAT+3 cycles with i_rsp_ready held high.
- **Mid-operation reset:** asynchronous reset in WAIT or RESP aborts the op immediately. All outputs return to reset values and no response is issued.
- **Ready/valid stability:** o_req_ready and o_rsp_valid are registered outputs with no combinational path from any input.

## Test plan
- **Basic sub:** WIDTH=4, LAT=1; the ALU model returns 4'hE / flag 4'b0010 for a sub of 3−5. Request arg0=3, arg1=5, oper=00 accepted at E0 → o_arg0=3, o_arg1=5, o_oper=00 after E0. Capture at E0+2 gives o_rsp_result=4'hE, o_rsp_flag=4'b0010, o_rsp_oper=00. Counters unchanged.
- **Response backpressure:** hold i_rsp_ready=0 for 5 cycles → o_rsp_valid stays 1 and o_rsp_* is stable. A new i_req_valid=1 is not accepted (o_req_ready=0). Release → handshake, then o_req_ready=1 the next cycle.
- **Counter saturation:** CNTW=2. Run 5 responses with flag 4'b1001 → o_err_cnt=3 and o_ovf_cnt=3 after the 3rd and stay 3. Then i_clr_cnt coincident with a capture of flag 4'b1001 → both counters read 0 after that edge.
- **LAT sweep:** LAT=0 and LAT=4 → capture exactly at E0+1 and E0+5 respectively. A bench model that changes i_alu_result one cycle early or late must produce a mismatch.
- **Mid-operation reset:** pull i_rstn low during WAIT → all outputs read 0 while reset is low. No o_rsp_valid appears after release. o_req_ready=1 one edge after release.
- **Back-to-back:** 4 queued requests with i_rsp_ready=1 → responses arrive in order, request-to-request spacing is LAT+3 cycles, and opcodes 00, 01, 10, 11 are echoed on o_rsp_oper.
